load_fire_unit: RTL and testbench
=================================

# load_fire_unit

Selects the oldest load-queue entry whose address is known and which has not yet executed, and issues it to the data-memory interface over a valid/ready handshake. It sits directly downstream of the load queue: it reads the queue's per-entry state and returns the `load_executed` / `load_executed_index` pulse that marks an entry as fired. One request is held in an output register; back-to-back issue at one load per cycle is supported.

## Interface
Parameters:
- `XLEN`, 32, address width
- `ROB_TAG_WIDTH`, 32, ROB tag width
- `LDQ_SIZE`, 32, load queue entries; must be a power of two
- `STQ_SIZE`, 32, store queue entries

Ports (name, direction, width, meaning):
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `ldq_valid`, `ldq_address_valid`, `ldq_executed`, `ldq_order_fail`  in  LDQ_SIZE  per-entry load queue state
- `ldq_address`  in  LDQ_SIZE×XLEN  per-entry load address
- `ldq_rob_tag`  in  LDQ_SIZE×ROB_TAG_WIDTH  per-entry ROB tag
- `ldq_store_mask`  in  LDQ_SIZE×STQ_SIZE  older stores for each load
- `ldq_head`  in  clog2(LDQ_SIZE)  index of the oldest load queue entry
- `stq_address_valid`  in  STQ_SIZE  store addresses known; used only under the configuration macro
- `mem_req_ready`  in  1  memory accepts the request
- `mem_req_valid`  out  1  request valid
- `mem_req_address`  out  XLEN  load address
- `mem_req_rob_tag`  out  ROB_TAG_WIDTH  tag; memory returns it on completion
- `mem_req_ldq_index`  out  clog2(LDQ_SIZE)  load queue index of the request
- `load_executed`  out  1  pulse: request accepted this cycle
- `load_executed_index`  out  clog2(LDQ_SIZE)  index of the accepted load

## Operation
- An entry i is eligible when all of the following hold:
  - `ldq_valid[i]`, `ldq_address_valid[i]`, `!ldq_executed[i]` and `!ldq_order_fail[i]`.
  - It is not the entry currently held in the request register.
- Age rank is `(i - ldq_head) mod LDQ_SIZE`; the lowest rank wins. Rank arithmetic is clog2(LDQ_SIZE) bits and wraps naturally.
- State machine:
  - IDLE: `mem_req_valid` = 0. If any entry is eligible, load the winner's address, tag and index into the request register and go to REQ.
  - REQ: `mem_req_valid` = 1. All request fields are held stable until `mem_req_ready`.
  - REQ with `mem_req_ready`: the request is accepted. If another entry is eligible, load it and stay in REQ; otherwise go to IDLE.
- `load_executed` = `mem_req_valid && mem_req_ready`, combinational; `load_executed_index` = `mem_req_ldq_index`.
- A pending entry cannot be freed by the load queue, because freeing requires commit, which requires success, which requires issue. No withdrawal path exists.

## Timing
- Reset values: state IDLE; `mem_req_valid`, `mem_req_address`, `mem_req_rob_tag`, `mem_req_ldq_index`, `load_executed` and `load_executed_index` all 0.
- Eligible in cycle N → `mem_req_valid` high in cycle N+1; minimum latency is 1 cycle.
- Acceptance in cycle M:
  - `load_executed` pulses in cycle M.
  - The load queue shows `ldq_executed` set from M+1.
  - The accepted index is excluded at the M edge by the "not currently held" rule, so the same entry is never issued twice.
- Throughput is 1 load per cycle while `mem_req_ready` stays high.
- Reset asserted in REQ: the request is dropped and the unit is in IDLE in the next cycle.
- Empty queue or nothing eligible: the unit stays in IDLE.
- All LDQ_SIZE entries eligible: the entry at `ldq_head` wins.

## Configuration
- `LOAD_FIRE_STORE_BLOCK_EN` defined: an entry is additionally ineligible while `|(ldq_store_mask[i] & ~stq_address_valid)`, i.e. while any older store has an unknown address (conservative, no speculation past unresolved stores).
- Undefined: `stq_address_valid` is ignored and loads issue speculatively; ordering is caught by `ldq_order_fail`.

## Structure
- Shared `lsu_pkg` holds:
  - `LDQ_IDX_W`, derived from LDQ_SIZE.
  - The state enum `load_fire_state_t` (IDLE, REQ).
- One sub-module, `oldest_ready_picker`: combinational, head-rotated priority select over an eligibility vector. It outputs `found` and `index`, and is reusable for store-queue firing.

## Test plan
- Entries 3 and 5 eligible, head = 4, ready held high → 5 issues first, then 3; `load_executed_index` = 5 then 3 in consecutive cycles.
- Entry 2 eligible, `mem_req_ready` low for 3 cycles → `mem_req_valid`, address and tag are stable for all 3 cycles; a single `load_executed` pulse with index 2 follows on ready.
- Head = 30 with LDQ_SIZE = 32, entries 31 and 0 eligible → 31 issues before 0 (wrap-around age ordering).
- Entry 7 accepted in cycle M with `ldq_executed[7]` still 0 in M → entry 7 is not reissued in M+1.
- Macro defined, entry 1 has `store_mask` = 0b100 and `stq_address_valid[2]` = 0 → no issue; setting `stq_address_valid[2]` = 1 → issue 1 cycle later. Macro undefined → issue immediately.
- Reset asserted while in REQ → `mem_req_valid` = 0 in the next cycle and no `load_executed` pulse.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared load/store-unit definitions: queue index width and the load-fire FSM states.
package lsu_pkg;

    localparam int LDQ_SIZE_DEF = 32;
    localparam int LDQ_IDX_W    = $clog2(LDQ_SIZE_DEF);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } load_fire_state_t;

endpackage

// File: rtl/oldest_ready_picker.sv
// Combinational head-rotated priority select: returns the eligible entry with the
// lowest age rank (index - head) mod N. Usable for load or store queue firing.
module oldest_ready_picker #(
    parameter int N = 32,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] head,
    output logic         found,
    output logic [W-1:0] index
);

    // Scan from the youngest rank down so the oldest eligible entry is written last.
    always_comb begin
        logic [W-1:0] idx_v;
        found = 1'b0;
        index = '0;
        idx_v = '0;
        for (int r = N - 1; r >= 0; r--) begin
            idx_v = head + W'(r);
            found = found | eligible[idx_v];
            index = eligible[idx_v] ? idx_v : index;
        end
    end

endmodule

// File: rtl/load_fire_unit.sv
// Issues the oldest ready, unexecuted load-queue entry to data memory over valid/ready.
// Optional macro LOAD_FIRE_STORE_BLOCK_EN holds loads behind older stores with unknown addresses.
module load_fire_unit
    import lsu_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int ROB_TAG_WIDTH = 32,
    parameter int LDQ_SIZE      = 32,
    parameter int STQ_SIZE      = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [LDQ_SIZE-1:0]                 ldq_valid,
    input  logic [LDQ_SIZE-1:0]                 ldq_address_valid,
    input  logic [LDQ_SIZE-1:0]                 ldq_executed,
    input  logic [LDQ_SIZE-1:0]                 ldq_order_fail,
    input  logic [LDQ_SIZE*XLEN-1:0]            ldq_address,
    input  logic [LDQ_SIZE*ROB_TAG_WIDTH-1:0]   ldq_rob_tag,
    input  logic [LDQ_SIZE*STQ_SIZE-1:0]        ldq_store_mask,
    input  logic [$clog2(LDQ_SIZE)-1:0]         ldq_head,
    input  logic [STQ_SIZE-1:0]                 stq_address_valid,
    input  logic                                mem_req_ready,
    output logic                                mem_req_valid,
    output logic [XLEN-1:0]                     mem_req_address,
    output logic [ROB_TAG_WIDTH-1:0]            mem_req_rob_tag,
    output logic [$clog2(LDQ_SIZE)-1:0]         mem_req_ldq_index,
    output logic                                load_executed,
    output logic [$clog2(LDQ_SIZE)-1:0]         load_executed_index
);

    localparam int IDX_W = $clog2(LDQ_SIZE);

    load_fire_state_t        state_q, state_d;
    logic [XLEN-1:0]          addr_q, addr_d;
    logic [ROB_TAG_WIDTH-1:0] tag_q, tag_d;
    logic [IDX_W-1:0]         idx_q, idx_d;

    logic [LDQ_SIZE-1:0]      elig_s;
    logic                     found_s;
    logic [IDX_W-1:0]         pick_idx_s;
    logic                     load_s;

    // The held entry is excluded so an accepted load cannot be reissued before
    // the queue reflects its executed bit.
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < LDQ_SIZE; i++) begin
            elig_s[i] = ldq_valid[i] & ldq_address_valid[i] & ~ldq_executed[i]
                      & ~ldq_order_fail[i]
                      & ~((state_q == REQ) && (idx_q == IDX_W'(i)))
`ifdef LOAD_FIRE_STORE_BLOCK_EN
                      & ~(|(ldq_store_mask[i*STQ_SIZE +: STQ_SIZE] & ~stq_address_valid))
`endif
                      ;
        end
    end

`ifndef LOAD_FIRE_STORE_BLOCK_EN
    logic unused_store_info_s;
    assign unused_store_info_s = ^{ldq_store_mask, stq_address_valid};
`endif

    oldest_ready_picker #(
        .N (LDQ_SIZE),
        .W (IDX_W)
    ) u_picker (
        .eligible (elig_s),
        .head     (ldq_head),
        .found    (found_s),
        .index    (pick_idx_s)
    );

    // Next-state and request-register load decision.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tag_d   = tag_q;
        idx_d   = idx_q;
        load_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    load_s  = 1'b1;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    load_s  = found_s;
                    state_d = found_s ? REQ : IDLE;
                end else begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load_s) begin
            addr_d = ldq_address[int'(pick_idx_s)*XLEN +: XLEN];
            tag_d  = ldq_rob_tag[int'(pick_idx_s)*ROB_TAG_WIDTH +: ROB_TAG_WIDTH];
            idx_d  = pick_idx_s;
        end else begin
            idx_d  = idx_q;
        end
    end

    // State and request register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            tag_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
        end
    end

    assign mem_req_valid       = (state_q == REQ);
    assign mem_req_address     = addr_q;
    assign mem_req_rob_tag     = tag_q;
    assign mem_req_ldq_index   = idx_q;
    assign load_executed       = mem_req_valid && mem_req_ready;
    assign load_executed_index = idx_q;

endmodule

// File: tb/tb_load_fire_unit.sv
// Directed table-driven bench for load_fire_unit plus hand sequences for multi-cycle cases.
module tb_load_fire_unit;

    logic               clk = 1'b0;
    logic               reset;
    logic [31:0]        ldq_valid, ldq_address_valid, ldq_executed, ldq_order_fail;
    logic [32*32-1:0]   ldq_address, ldq_rob_tag, ldq_store_mask;
    logic [4:0]         ldq_head;
    logic [31:0]        stq_address_valid;
    logic               mem_req_ready;
    logic               mem_req_valid;
    logic [31:0]        mem_req_address, mem_req_rob_tag;
    logic [4:0]         mem_req_ldq_index, load_executed_index;
    logic               load_executed;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_fire_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .ldq_valid           (ldq_valid),
        .ldq_address_valid   (ldq_address_valid),
        .ldq_executed        (ldq_executed),
        .ldq_order_fail      (ldq_order_fail),
        .ldq_address         (ldq_address),
        .ldq_rob_tag         (ldq_rob_tag),
        .ldq_store_mask      (ldq_store_mask),
        .ldq_head            (ldq_head),
        .stq_address_valid   (stq_address_valid),
        .mem_req_ready       (mem_req_ready),
        .mem_req_valid       (mem_req_valid),
        .mem_req_address     (mem_req_address),
        .mem_req_rob_tag     (mem_req_rob_tag),
        .mem_req_ldq_index   (mem_req_ldq_index),
        .load_executed       (load_executed),
        .load_executed_index (load_executed_index)
    );

    typedef struct {
        logic [31:0] v, av, ex, of;
        logic [4:0]  head;
        logic        rdy;
        logic        ev;
        logic [4:0]  eidx;
        logic        eex;
    } vec_t;

    vec_t tbl[15];

    function automatic logic [31:0] b(input int n);
        b = 32'd1 << n;
    endfunction

    function automatic vec_t mk(input logic [31:0] v, input logic [31:0] ex, input logic [31:0] of,
                                input logic [4:0] head, input logic rdy, input logic ev,
                                input logic [4:0] eidx, input logic eex);
        vec_t t;
        t.v = v; t.av = v; t.ex = ex; t.of = of; t.head = head;
        t.rdy = rdy; t.ev = ev; t.eidx = eidx; t.eex = eex;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_req(input string name, input logic [4:0] idx);
        chk({name, "_valid"}, {31'd0, mem_req_valid}, 32'd1);
        chk({name, "_idx"},   {27'd0, mem_req_ldq_index}, {27'd0, idx});
        chk({name, "_addr"},  mem_req_address, 32'h1000 + 32'(idx) * 32'd4);
        chk({name, "_tag"},   mem_req_rob_tag, 32'd100 + 32'(idx));
    endtask

    initial begin
        reset = 1'b1;
        ldq_valid = '0; ldq_address_valid = '0; ldq_executed = '0; ldq_order_fail = '0;
        ldq_store_mask = '0; ldq_head = '0; stq_address_valid = '1; mem_req_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ldq_address[i*32 +: 32] = 32'h1000 + 32'(i) * 32'd4;
            ldq_rob_tag[i*32 +: 32] = 32'd100 + 32'(i);
        end

        tbl[0]  = mk(32'd0,          32'd0,              32'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0);
        tbl[1]  = mk(b(3) | b(5),    32'd0,              32'd0,  5'd4,  1'b1, 1'b0, 5'd0,  1'b0);
        tbl[2]  = mk(b(3) | b(5),    32'd0,              32'd0,  5'd4,  1'b1, 1'b1, 5'd5,  1'b1);
        tbl[3]  = mk(b(3) | b(5),    b(5),               32'd0,  5'd4,  1'b1, 1'b1, 5'd3,  1'b1);
        tbl[4]  = mk(b(3) | b(5),    b(3) | b(5),        32'd0,  5'd4,  1'b1, 1'b0, 5'd0,  1'b0);
        tbl[5]  = mk(b(31) | b(0),   32'd0,              32'd0,  5'd30, 1'b1, 1'b0, 5'd0,  1'b0);
        tbl[6]  = mk(b(31) | b(0),   32'd0,              32'd0,  5'd30, 1'b1, 1'b1, 5'd31, 1'b1);
        tbl[7]  = mk(b(31) | b(0),   b(31),              32'd0,  5'd30, 1'b1, 1'b1, 5'd0,  1'b1);
        tbl[8]  = mk(b(31) | b(0),   b(31) | b(0),       32'd0,  5'd30, 1'b1, 1'b0, 5'd0,  1'b0);
        tbl[9]  = mk(32'hFFFF_FFFF,  32'd0,              32'd0,  5'd17, 1'b0, 1'b0, 5'd0,  1'b0);
        tbl[10] = mk(32'hFFFF_FFFF,  32'd0,              32'd0,  5'd17, 1'b0, 1'b1, 5'd17, 1'b0);
        tbl[11] = mk(32'hFFFF_FFFF,  32'd0,              32'd0,  5'd17, 1'b1, 1'b1, 5'd17, 1'b1);
        tbl[12] = mk(32'hFFFF_FFFF,  b(17),              32'd0,  5'd17, 1'b0, 1'b1, 5'd18, 1'b0);
        tbl[13] = mk(32'hFFFF_FFFF,  b(17),       32'hFFFF_FFFF, 5'd17, 1'b1, 1'b1, 5'd18, 1'b1);
        tbl[14] = mk(32'hFFFF_FFFF,  b(17),       32'hFFFF_FFFF, 5'd17, 1'b1, 1'b0, 5'd0,  1'b0);

        // Reset values
        repeat (2) cyc();
        chk("rst_valid",    {31'd0, mem_req_valid}, 32'd0);
        chk("rst_addr",     mem_req_address, 32'd0);
        chk("rst_tag",      mem_req_rob_tag, 32'd0);
        chk("rst_idx",      {27'd0, mem_req_ldq_index}, 32'd0);
        chk("rst_exec",     {31'd0, load_executed}, 32'd0);
        chk("rst_exec_idx", {27'd0, load_executed_index}, 32'd0);
        reset = 1'b0;
        cyc();

        // Table: expected values describe outputs in the cycle the inputs are applied
        for (int k = 0; k < 15; k++) begin
            ldq_valid = tbl[k].v; ldq_address_valid = tbl[k].av;
            ldq_executed = tbl[k].ex; ldq_order_fail = tbl[k].of;
            ldq_head = tbl[k].head; mem_req_ready = tbl[k].rdy;
            #1;
            chk($sformatf("vec%0d_valid", k), {31'd0, mem_req_valid}, {31'd0, tbl[k].ev});
            chk($sformatf("vec%0d_exec", k),  {31'd0, load_executed}, {31'd0, tbl[k].eex});
            if (tbl[k].ev) begin
                chk_req($sformatf("vec%0d", k), tbl[k].eidx);
                chk($sformatf("vec%0d_exec_idx", k), {27'd0, load_executed_index},
                    {27'd0, tbl[k].eidx});
            end
            cyc();
        end

        // Stall: entry 2 held stable for 3 cycles of ready low, then a single pulse
        ldq_valid = b(2); ldq_address_valid = b(2); ldq_executed = '0; ldq_order_fail = '0;
        ldq_head = 5'd0; mem_req_ready = 1'b0;
        #1 chk("stall_idle", {31'd0, mem_req_valid}, 32'd0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            chk_req($sformatf("stall%0d", k), 5'd2);
            chk($sformatf("stall%0d_exec", k), {31'd0, load_executed}, 32'd0);
            cyc();
        end
        mem_req_ready = 1'b1;
        #1;
        chk("stall_accept", {31'd0, load_executed}, 32'd1);
        chk("stall_accept_idx", {27'd0, load_executed_index}, 32'd2);
        cyc();
        ldq_executed = b(2);
        #1;
        chk("stall_after_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("stall_after_exec", {31'd0, load_executed}, 32'd0);

        // Entry 7 accepted while its executed bit is still clear: not reissued
        ldq_valid = b(7); ldq_address_valid = b(7); ldq_executed = '0;
        cyc();
        #1;
        chk_req("e7", 5'd7);
        chk("e7_exec", {31'd0, load_executed}, 32'd1);
        cyc();
        ldq_executed = b(7);
        #1 chk("e7_no_reissue", {31'd0, mem_req_valid}, 32'd0);
        cyc();
        chk("e7_still_idle", {31'd0, mem_req_valid}, 32'd0);

        // Older store with unknown address
        ldq_valid = b(1); ldq_address_valid = b(1); ldq_executed = '0;
        ldq_store_mask[1*32 +: 32] = 32'b100; stq_address_valid = 32'hFFFF_FFFB;
        mem_req_ready = 1'b0;
        #1 chk("stq_idle", {31'd0, mem_req_valid}, 32'd0);
        cyc();
`ifdef LOAD_FIRE_STORE_BLOCK_EN
        chk("stq_blocked", {31'd0, mem_req_valid}, 32'd0);
        stq_address_valid = 32'hFFFF_FFFF;
        #1 chk("stq_blocked2", {31'd0, mem_req_valid}, 32'd0);
        cyc();
`endif
        chk_req("stq_issue", 5'd1);
        mem_req_ready = 1'b1;
        cyc();
        ldq_executed = b(1); mem_req_ready = 1'b0; ldq_store_mask = '0; stq_address_valid = '1;
        #1 chk("stq_done", {31'd0, mem_req_valid}, 32'd0);

        // Reset while a request is pending
        ldq_valid = b(4); ldq_address_valid = b(4); ldq_executed = '0;
        cyc();
        cyc();
        chk_req("rreq", 5'd4);
        reset = 1'b1;
        #1 chk("rreq_exec_during", {31'd0, load_executed}, 32'd0);
        cyc();
        chk("rreq_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rreq_exec", {31'd0, load_executed}, 32'd0);
        chk("rreq_idx", {27'd0, mem_req_ldq_index}, 32'd0);
        chk("rreq_addr", mem_req_address, 32'd0);
        reset = 1'b0; ldq_valid = '0; ldq_address_valid = '0;
        cyc();
        chk("rreq_idle", {31'd0, mem_req_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
